// File: rtl/l1_prefetch_issue_ctrl.sv
// Slot-based prefetch issue controller: tracks line-aligned candidates, issues when the core is idle, retries nacked requests.
// Optional build macro L1PF_DEDUP_EN: drop candidates whose line is already tracked.
module l1_prefetch_issue_ctrl #(
  parameter int ADDR_BITS  = 40,
  parameter int LINE_SHIFT = 6,
  parameter int DEPTH      = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pf_valid,
  input  logic [ADDR_BITS-1:0] pf_addr,
  input  logic                 pf_write,
  output logic                 pf_ready,
  input  logic                 cpu_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_req_valid,
  output logic [ADDR_BITS-1:0] dmem_req_bits_addr,
  output logic                 dmem_req_bits_write,
  input  logic                 dmem_nack,
  output logic                 busy,
  output logic [7:0]           drop_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_BITS-1:0] LINE_MASK =
    ~((ADDR_BITS'(1) << LINE_SHIFT) - ADDR_BITS'(1));

  // state         | meaning
  // SLOT_FREE     | slot empty, can take a new candidate
  // SLOT_WAIT     | line held, waiting for an issue opportunity
  // SLOT_INFLIGHT | request fired, nack window still open
  typedef enum logic [1:0] {SLOT_FREE, SLOT_WAIT, SLOT_INFLIGHT} slot_state_t;

  slot_state_t          slot_st_q    [DEPTH];
  slot_state_t          slot_st_d    [DEPTH];
  logic [ADDR_BITS-1:0] slot_addr_q  [DEPTH];
  logic                 slot_wr_q    [DEPTH];
  logic [2:0]           slot_retry_q [DEPTH];
  logic [2:0]           slot_retry_d [DEPTH];

  logic             s1_vld_q, s2_vld_q;
  logic [IDX_W-1:0] s1_idx_q, s2_idx_q;
  logic [7:0]       drop_count_q, drop_d;

  logic                 free_any, wait_any, dup_hit, any_busy_slot;
  logic [IDX_W-1:0]     free_idx, wait_idx;
  logic [ADDR_BITS-1:0] line_addr;
  logic                 fire, enq, retry_ok;

  assign line_addr = pf_addr & LINE_MASK;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    free_any      = 1'b0;
    free_idx      = '0;
    wait_any      = 1'b0;
    wait_idx      = '0;
    dup_hit       = 1'b0;
    any_busy_slot = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slot_st_q[i] == SLOT_FREE) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end else begin
        any_busy_slot = 1'b1;
      end
      if (slot_st_q[i] == SLOT_WAIT) begin
        wait_any = 1'b1;
        wait_idx = IDX_W'(i);
      end
    end
`ifdef L1PF_DEDUP_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_st_q[i] != SLOT_FREE && slot_addr_q[i] == line_addr) dup_hit = 1'b1;
    end
`else
    dup_hit = 1'b0;
`endif
  end

  assign pf_ready            = free_any;
  assign dmem_req_valid      = wait_any && !cpu_req_valid;
  assign dmem_req_bits_addr  = wait_any ? slot_addr_q[wait_idx] : '0;
  assign dmem_req_bits_write = wait_any ? slot_wr_q[wait_idx] : 1'b0;
  assign busy                = any_busy_slot || s1_vld_q || s2_vld_q;
  assign drop_count          = drop_count_q;

  assign fire     = dmem_req_valid && dmem_req_ready;
  assign enq      = pf_valid && free_any && !dup_hit;
  assign retry_ok = (int'(slot_retry_q[s2_idx_q]) + 1) < MAX_RETRY;

  // Enqueue, fire and stage-2 resolution always touch distinct slots
  // (FREE, WAIT and INFLIGHT respectively), so their order here is free.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_st_d[i]    = slot_st_q[i];
      slot_retry_d[i] = slot_retry_q[i];
    end
    drop_d = drop_count_q;
    if (enq) begin
      slot_st_d[free_idx]    = SLOT_WAIT;
      slot_retry_d[free_idx] = '0;
    end
    if (fire) slot_st_d[wait_idx] = SLOT_INFLIGHT;
    if (s2_vld_q) begin
      if (!dmem_nack) begin
        slot_st_d[s2_idx_q] = SLOT_FREE;
      end else if (retry_ok) begin
        slot_st_d[s2_idx_q]    = SLOT_WAIT;
        slot_retry_d[s2_idx_q] = slot_retry_q[s2_idx_q] + 3'd1;
      end else begin
        slot_st_d[s2_idx_q] = SLOT_FREE;
        if (drop_d != 8'hff) drop_d = drop_d + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_st_q[i]    <= SLOT_FREE;
        slot_addr_q[i]  <= '0;
        slot_wr_q[i]    <= 1'b0;
        slot_retry_q[i] <= '0;
      end
      s1_vld_q     <= 1'b0;
      s1_idx_q     <= '0;
      s2_vld_q     <= 1'b0;
      s2_idx_q     <= '0;
      drop_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_st_q[i]    <= slot_st_d[i];
        slot_retry_q[i] <= slot_retry_d[i];
      end
      if (enq) begin
        slot_addr_q[free_idx] <= line_addr;
        slot_wr_q[free_idx]   <= pf_write;
      end
      s1_vld_q     <= fire;
      s1_idx_q     <= wait_idx;
      s2_vld_q     <= s1_vld_q;
      s2_idx_q     <= s1_idx_q;
      drop_count_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_l1_prefetch_issue_ctrl.sv
// Bench for l1_prefetch_issue_ctrl: vector table, directed corner sequences, random run against a queue-based model.
module tb_l1_prefetch_issue_ctrl;
  localparam int AB = 40;
  localparam int DP = 4;
  localparam int MR = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          pf_valid, pf_write, pf_ready;
  logic [AB-1:0] pf_addr;
  logic          cpu_req_valid, dmem_req_ready, dmem_req_valid, dmem_req_bits_write, dmem_nack, busy;
  logic [AB-1:0] dmem_req_bits_addr;
  logic [7:0]    drop_count;

  always #5 clock = ~clock;

  l1_prefetch_issue_ctrl #(.ADDR_BITS(AB), .LINE_SHIFT(6), .DEPTH(DP), .MAX_RETRY(MR)) dut (
    .clock(clock), .reset(reset),
    .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_write(pf_write), .pf_ready(pf_ready),
    .cpu_req_valid(cpu_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_valid(dmem_req_valid), .dmem_req_bits_addr(dmem_req_bits_addr),
    .dmem_req_bits_write(dmem_req_bits_write), .dmem_nack(dmem_nack),
    .busy(busy), .drop_count(drop_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [AB-1:0] fire_q[$];
  always @(negedge clock)
    if (!reset && dmem_req_valid && dmem_req_ready) fire_q.push_back(dmem_req_bits_addr);

  task automatic idle_inputs();
    pf_valid = 0; pf_addr = '0; pf_write = 0;
    cpu_req_valid = 0; dmem_req_ready = 1; dmem_nack = 0;
  endtask

  task automatic next();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    next(); next();
    reset = 0;
  endtask

  typedef struct {
    logic pv; logic [AB-1:0] pa; logic pw; logic cpu; logic rdy; logic nack;
    logic er; logic ev; logic [AB-1:0] ea; logic ew; logic eb; logic [7:0] ed;
  } vec_t;
  vec_t vt[$];

  function automatic void tv(input logic pv, input logic [AB-1:0] pa, input logic pw, input logic cpu,
                             input logic rdy, input logic nack, input logic er, input logic ev,
                             input logic [AB-1:0] ea, input logic ew, input logic eb, input logic [7:0] ed);
    vec_t v;
    v.pv = pv; v.pa = pa; v.pw = pw; v.cpu = cpu; v.rdy = rdy; v.nack = nack;
    v.er = er; v.ev = ev; v.ea = ea; v.ew = ew; v.eb = eb; v.ed = ed;
    vt.push_back(v);
  endfunction

  // Reference model: slot codes 0 free / 1 waiting / 2 in flight; fired
  // requests are kept with their fire time and resolved two cycles later.
  typedef struct { int slot; int t; } fl_t;
  int            m_st[DP];
  logic [AB-1:0] m_addr[DP];
  logic          m_wr[DP];
  int            m_retry[DP];
  fl_t           m_fl[$];
  int            m_now, m_drop;

  function automatic void m_reset();
    for (int i = 0; i < DP; i++) begin m_st[i] = 0; m_addr[i] = '0; m_wr[i] = 0; m_retry[i] = 0; end
    m_fl.delete(); m_now = 0; m_drop = 0;
  endfunction

  function automatic int m_first(input int code);
    for (int i = 0; i < DP; i++) if (m_st[i] == code) return i;
    return -1;
  endfunction

  function automatic void m_step();
    int wsel, fsel, s;
    bit fire, dup;
    logic [AB-1:0] al;
    wsel = m_first(1);
    fsel = m_first(0);
    al   = pf_addr & ~40'h3f;
    fire = !cpu_req_valid && wsel >= 0 && dmem_req_ready;
    dup  = 0;
`ifdef L1PF_DEDUP_EN
    for (int i = 0; i < DP; i++) if (m_st[i] != 0 && m_addr[i] == al) dup = 1;
`endif
    if (m_fl.size() > 0 && m_fl[0].t == m_now - 2) begin
      s = m_fl[0].slot;
      void'(m_fl.pop_front());
      if (!dmem_nack) m_st[s] = 0;
      else if (m_retry[s] + 1 < MR) begin m_retry[s]++; m_st[s] = 1; end
      else begin m_st[s] = 0; if (m_drop < 255) m_drop++; end
    end
    if (fire) begin
      fl_t f;
      f.slot = wsel; f.t = m_now;
      m_st[wsel] = 2;
      m_fl.push_back(f);
    end
    if (pf_valid && fsel >= 0 && !dup) begin
      m_st[fsel] = 1; m_addr[fsel] = al; m_wr[fsel] = pf_write; m_retry[fsel] = 0;
    end
    m_now++;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_fires, waited;
    bit seen;
    logic [AB-1:0] exp_order[5];

    //  pv  pa                pw cpu rdy nk | rdy vld addr              wr busy drop
    tv(1, 40'h10_0000_0047, 0, 0, 1, 0,   1, 0, 40'h0,            0, 0, 0);
    tv(0, 40'h0,            0, 0, 1, 0,   1, 1, 40'h10_0000_0040, 0, 1, 0);
    tv(0, 40'h0,            0, 0, 1, 0,   1, 0, 40'h0,            0, 1, 0);
    tv(0, 40'h0,            0, 0, 1, 0,   1, 0, 40'h0,            0, 1, 0);
    tv(0, 40'h0,            0, 0, 1, 1,   1, 0, 40'h0,            0, 0, 0);
    tv(1, 40'h3000,         0, 0, 1, 0,   1, 0, 40'h0,            0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tv(0, 40'h0, 0, 0, 1, 0,   1, 1, 40'h3000, 0, 1, 0);
      tv(0, 40'h0, 0, 0, 1, 1,   1, 0, 40'h0,    0, 1, 0);
      tv(0, 40'h0, 0, 0, 1, 1,   1, 0, 40'h0,    0, 1, 0);
    end
    tv(0, 40'h0,            0, 0, 1, 0,   1, 0, 40'h0,            0, 0, 1);
    tv(1, 40'h5000,         1, 1, 1, 0,   1, 0, 40'h0,            0, 0, 1);
    for (int k = 0; k < 5; k++)
      tv(0, 40'h0, 0, 1, 1, 0,   1, 0, 40'h5000, 1, 1, 1);
    tv(0, 40'h0,            0, 0, 1, 0,   1, 1, 40'h5000,         1, 1, 1);
    tv(0, 40'h0,            0, 0, 1, 0,   1, 0, 40'h0,            0, 1, 1);
    tv(0, 40'h0,            0, 0, 1, 0,   1, 0, 40'h0,            0, 1, 1);
    tv(0, 40'h0,            0, 0, 1, 0,   1, 0, 40'h0,            0, 0, 1);

    do_reset();
    foreach (vt[i]) begin
      pf_valid = vt[i].pv; pf_addr = vt[i].pa; pf_write = vt[i].pw;
      cpu_req_valid = vt[i].cpu; dmem_req_ready = vt[i].rdy; dmem_nack = vt[i].nack;
      @(negedge clock);
      check($sformatf("vec%0d_pf_ready", i), pf_ready, vt[i].er);
      check($sformatf("vec%0d_req_valid", i), dmem_req_valid, vt[i].ev);
      check($sformatf("vec%0d_req_addr", i), dmem_req_bits_addr, vt[i].ea);
      check($sformatf("vec%0d_req_write", i), dmem_req_bits_write, vt[i].ew);
      check($sformatf("vec%0d_busy", i), busy, vt[i].eb);
      check($sformatf("vec%0d_drop", i), drop_count, vt[i].ed);
      next();
    end

    // Asynchronous reset one cycle after a fire, with nack held high.
    idle_inputs();
    pf_valid = 1; pf_addr = 40'h6000;
    next();
    pf_valid = 0;
    @(negedge clock);
    check("rst_fire_present", dmem_req_valid, 1'b1);
    next();
    #2;
    dmem_nack = 1;
    reset = 1;
    #1;
    check("rst_req_valid", dmem_req_valid, 1'b0);
    check("rst_req_addr", dmem_req_bits_addr, 40'h0);
    check("rst_req_write", dmem_req_bits_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_count, 8'd0);
    check("rst_pf_ready", pf_ready, 1'b1);
    next(); next();
    reset = 0;
    fire_q.delete();
    repeat (6) next();
    dmem_nack = 0;
    @(negedge clock);
    check("rst_no_reissue", fire_q.size(), 0);
    check("rst_after_drop", drop_count, 8'd0);
    check("rst_after_busy", busy, 1'b0);
    next();

    // Same line offered twice while the port is stalled.
    do_reset();
    fire_q.delete();
    dmem_req_ready = 0;
    pf_valid = 1; pf_addr = 40'h2000;
    @(negedge clock); check("dup_ready_first", pf_ready, 1'b1);
    next();
    pf_addr = 40'h2010;
    @(negedge clock); check("dup_ready_second", pf_ready, 1'b1);
    next();
    pf_valid = 0;
    next();
    dmem_req_ready = 1;
    repeat (12) next();
`ifdef L1PF_DEDUP_EN
    exp_fires = 1;
`else
    exp_fires = 2;
`endif
    check("dup_fire_count", fire_q.size(), exp_fires);
    foreach (fire_q[i]) check($sformatf("dup_fire%0d_addr", i), fire_q[i], 40'h2000);
    @(negedge clock); check("dup_idle_busy", busy, 1'b0);
    next();

    // Fill all slots, hold a fifth candidate until the first completion.
    do_reset();
    fire_q.delete();
    dmem_req_ready = 0;
    for (int k = 0; k < 4; k++) begin
      pf_valid = 1; pf_addr = AB'(k * 64);
      next();
    end
    pf_addr = 40'h100;
    @(negedge clock); check("full_pf_ready", pf_ready, 1'b0);
    next();
    dmem_req_ready = 1;
    waited = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (pf_ready) seen = 1; else waited++;
      next();
    end
    check("full_accept_seen", seen, 1'b1);
    check("full_hold_cycles", waited, 3);
    pf_valid = 0;
    repeat (12) next();
    exp_order[0] = 40'h0; exp_order[1] = 40'h40; exp_order[2] = 40'h80;
    exp_order[3] = 40'hC0; exp_order[4] = 40'h100;
    check("full_fire_count", fire_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < fire_q.size()) check($sformatf("full_order%0d", i), fire_q[i], exp_order[i]);

    // Saturation of the drop counter under continuous nacks.
    do_reset();
    dmem_nack = 1;
    for (int c = 0; c < 1200; c++) begin
      pf_valid = 1; pf_addr = AB'(c) << 6;
      next();
    end
    idle_inputs();
    dmem_nack = 1;
    repeat (12) next();
    @(negedge clock); check("sat_drop", drop_count, 8'hff);
    next();

    // Randomized run against the reference model.
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      int w;
      pf_valid       = ($urandom_range(0, 1) == 1);
      pf_addr        = 40'h80_0000_0000 | (AB'($urandom_range(0, 5)) << 6) | AB'($urandom_range(0, 63));
      pf_write       = ($urandom_range(0, 1) == 1);
      cpu_req_valid  = ($urandom_range(0, 3) == 0);
      dmem_req_ready = ($urandom_range(0, 9) < 7);
      dmem_nack      = ($urandom_range(0, 9) < 3);
      @(negedge clock);
      w = m_first(1);
      check("rnd_pf_ready", pf_ready, m_first(0) >= 0);
      check("rnd_req_valid", dmem_req_valid, !cpu_req_valid && w >= 0);
      check("rnd_req_addr", dmem_req_bits_addr, (w >= 0) ? m_addr[w] : 40'h0);
      check("rnd_req_write", dmem_req_bits_write, (w >= 0) ? m_wr[w] : 1'b0);
      check("rnd_busy", busy, (m_first(1) >= 0) || (m_first(2) >= 0) || (m_fl.size() > 0));
      check("rnd_drop", drop_count, 8'(m_drop));
      m_step();
      next();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
